// File: rtl/pcpu_mem_access.sv
// MEM-stage load/store unit: lane extract/extend for loads, RMW for sub-word stores.
// Optional MISALIGN_TRAP_EN: flag and suppress misaligned H/W accesses.
module pcpu_mem_access #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        mem_op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_vld,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  input  logic [31:0]       dm_dout,
  output logic              misalign
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] rmw_addr;
  logic [31:0]       rmw_data;
  logic [31:0]       merged;
  logic [31:0]       ld_val;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              op_b, op_h, op_u;
  logic              st, ld, sub, idle, mis;
  logic              unused;

  assign unused = ^addr[31:ADDR_W];

  assign op_b = (mem_op == 3'b000) || (mem_op == 3'b100);
  assign op_h = (mem_op == 3'b001) || (mem_op == 3'b101);
  assign op_u = mem_op[2];
  assign sub  = op_b || op_h;
  assign st   = mem_wr;
  assign ld   = mem_rd && !mem_wr;
  assign idle = (state == IDLE);

`ifdef MISALIGN_TRAP_EN
  assign mis = (op_h && addr[0]) || (!sub && (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign ld_byte = dm_dout[{addr[1:0], 3'b000} +: 8];
  assign ld_half = dm_dout[{addr[1], 4'b0000} +: 16];

  always_comb begin
    merged = dm_dout;
    if (op_b)
      merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    else if (op_h)
      merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
  end

  always_comb begin
    ld_val = dm_dout;
    if (op_b)
      ld_val = {{24{!op_u && ld_byte[7]}}, ld_byte};
    else if (op_h)
      ld_val = {{16{!op_u && ld_half[15]}}, ld_half};
  end

  // Outputs are forced quiet while reset is held, even mid-RMW.
  always_comb begin
    stall   = 1'b0;
    dm_rd   = 1'b0;
    dm_wr   = 1'b0;
    dm_din  = wdata;
    dm_addr = {addr[ADDR_W-1:2], 2'b00};
    if (!rstn) begin
      dm_din = wdata;
    end else if (!idle) begin
      dm_wr   = 1'b1;
      dm_din  = rmw_data;
      dm_addr = rmw_addr;
    end else if (st && !mis) begin
      if (sub) begin
        dm_rd = 1'b1;
        stall = 1'b1;
      end else begin
        dm_wr = 1'b1;
      end
    end else if (ld && !mis) begin
      dm_rd = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rmw_addr <= '0;
      rmw_data <= '0;
    end else if (!idle) begin
      state <= IDLE;
    end else if (st && sub && !mis) begin
      state    <= RMW_WR;
      rmw_addr <= {addr[ADDR_W-1:2], 2'b00};
      rmw_data <= merged;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata     <= '0;
      rdata_vld <= 1'b0;
    end else begin
      rdata_vld <= idle && ld;
      if (idle && ld)
        rdata <= mis ? 32'h0 : ld_val;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      misalign <= 1'b0;
    else
      misalign <= idle && (st || ld) && mis;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pcpu_mem_access.sv
// Bench for pcpu_mem_access: byte-array reference memory, queued expectations,
// independent monitor on dm writes and load results.
module tb_pcpu_mem_access;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  mem_op = 3'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_vld;
  logic        dm_rd;
  logic        dm_wr;
  logic [6:0]  dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        misalign;

  pcpu_mem_access dut (
    .clk(clk), .rstn(rstn), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_op(mem_op), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .rdata_vld(rdata_vld), .dm_rd(dm_rd),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_dout(dm_dout), .misalign(misalign)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [32];
  assign dm_dout = dmem[dm_addr[6:2]];
  always @(posedge clk) if (dm_wr) dmem[dm_addr[6:2]] <= dm_din;

  logic [7:0] refm [128];

  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q [$];
  logic [31:0] rd_q [$];
  int passed = 0;
  int total = 0;
  int exp_stall = 0, seen_stall = 0;
  int exp_mis = 0, seen_mis = 0;
  bit done = 0;

  task automatic check(string nm, bit ok, logic [63:0] act, logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int size_of(logic [2:0] op);
    if (op == 3'b000 || op == 3'b100) return 1;
    if (op == 3'b001 || op == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] word_at(int a);
    int b = a - (a % 4);
    return refm[b] + refm[b+1] * 256 + refm[b+2] * 65536 + refm[b+3] * 16777216;
  endfunction

  function automatic bit is_mis(logic [2:0] op, int a);
`ifdef MISALIGN_TRAP_EN
    int s = size_of(op);
    return (s > 1) && (a % s != 0);
`else
    return 0;
`endif
  endfunction

  task automatic model(bit rd, bit wr, logic [2:0] op, logic [31:0] a32, logic [31:0] wd);
    int a = int'(a32 % 128);
    int s = size_of(op);
    int b = a - (a % s);
    logic [31:0] v;
    if (wr) begin
      if (is_mis(op, a)) begin
        exp_mis++;
      end else begin
        for (int i = 0; i < s; i++) refm[b+i] = wd[8*i +: 8];
        wr_q.push_back('{a: 7'(a - a % 4), d: word_at(a)});
        if (s < 4) exp_stall++;
      end
    end else if (rd) begin
      if (is_mis(op, a)) begin
        exp_mis++;
        rd_q.push_back(32'h0);
      end else begin
        v = 0;
        for (int i = 0; i < s; i++) v = v + refm[b+i] * (1 << (8*i));
        if (op == 3'b000 && v >= 128) v = v - 256;
        if (op == 3'b001 && v >= 32768) v = v - 65536;
        rd_q.push_back(v);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 once the request is accepted.
  task automatic issue(bit rd, bit wr, logic [2:0] op, logic [31:0] a, logic [31:0] wd);
    bit s;
    bit ok = 0;
    model(rd, wr, op, a, wd);
    mem_rd = rd; mem_wr = wr; mem_op = op; addr = a; wdata = wd;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) s = stall;
      @(posedge clk) #1;
      if (!s) begin ok = 1; break; end
    end
    if (!ok) check("stall_timeout", 0, 64'(stall), 64'h0);
    mem_rd = 0; mem_wr = 0;
  endtask

  task automatic idle(int n);
    mem_rd = 0; mem_wr = 0;
    repeat (n) @(posedge clk) #1;
  endtask

  always @(negedge clk) begin
    if (rstn && !done) begin
      wr_t e;
      logic [31:0] r;
      if (stall) seen_stall++;
      if (misalign) seen_mis++;
      if (dm_wr) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 0, {25'b0, dm_addr, dm_din}, 64'h0);
        end else begin
          e = wr_q.pop_front();
          check("dm_write", dm_addr == e.a && dm_din == e.d,
                {25'b0, dm_addr, dm_din}, {25'b0, e.a, e.d});
        end
      end
      if (rdata_vld) begin
        if (rd_q.size() == 0) begin
          check("unexpected_load", 0, 64'(rdata), 64'h0);
        end else begin
          r = rd_q.pop_front();
          check("load_data", rdata == r, 64'(rdata), 64'(r));
        end
      end
    end
  end

  initial begin
    logic [31:0] w, a;
    logic [2:0]  op;
    bit          rd, wr;
    logic [2:0]  st_ops [6];
    st_ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      dmem[i] = w;
      for (int j = 0; j < 4; j++) refm[4*i+j] = w[8*j +: 8];
    end
    #12;
    check("rst_rdata", rdata == 0, 64'(rdata), 64'h0);
    check("rst_ctrl", {rdata_vld, misalign, stall, dm_rd, dm_wr} == 5'b0,
          64'({rdata_vld, misalign, stall, dm_rd, dm_wr}), 64'h0);
    @(negedge clk) rstn = 1;
    @(posedge clk) #1;

    issue(0, 1, 3'b010, 32'h08, 32'hDEADBEEF);
    issue(0, 1, 3'b000, 32'h09, 32'h123456AA);
    issue(1, 0, 3'b000, 32'h0B, 0);
    issue(1, 0, 3'b100, 32'h0B, 0);
    issue(1, 0, 3'b001, 32'h0A, 0);
    issue(1, 0, 3'b101, 32'h0A, 0);
    issue(0, 1, 3'b010, 32'h04, 32'h12345678);
    issue(1, 0, 3'b010, 32'h06, 0);
    issue(0, 1, 3'b001, 32'h1E, 32'hFFFF8001);
    issue(0, 1, 3'b000, 32'h1C, 32'h00000055);
    issue(1, 0, 3'b010, 32'hFFFFFF9C, 0);
    idle(2);

    // Reset while the RMW write cycle is on the bus.
    w = word_at(12);
    exp_stall++;
    mem_wr = 1; mem_op = 3'b001; addr = 32'h0C; wdata = 32'h0000BEEF;
    @(posedge clk) #1;
    check("rmw_entered", dm_wr, 64'(dm_wr), 64'h1);
    rstn = 0;
    #1;
    check("rst_mid_rmw", {dm_wr, dm_rd, stall, rdata_vld} == 4'b0 && rdata == 0,
          {27'b0, dm_wr, dm_rd, stall, rdata_vld, rdata}, 64'h0);
    mem_wr = 0;
    @(negedge clk) #1 rstn = 1;
    @(posedge clk) #1;
    check("rmw_mem_kept", dmem[3] == w, 64'(dmem[3]), 64'(w));
    issue(1, 0, 3'b010, 32'h0C, 0);

    for (int n = 0; n < 300; n++) begin
      wr = ($urandom_range(0, 1) == 1);
      rd = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
      op = wr ? st_ops[$urandom_range(0, 5)] : 3'($urandom);
      a = $urandom;
      issue(rd, wr, op, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    done = 1;
    check("writes_drained", wr_q.size() == 0, 64'(wr_q.size()), 64'h0);
    check("loads_drained", rd_q.size() == 0, 64'(rd_q.size()), 64'h0);
    check("stall_cycles", seen_stall == exp_stall, 64'(seen_stall), 64'(exp_stall));
    check("misalign_pulses", seen_mis == exp_mis, 64'(seen_mis), 64'(exp_mis));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
